// File: rtl/pe_in_arb.sv
// pe_in_arb -- packet-granular two-source arbiter feeding the D input of a PE slot.
//
// Two 64-bit sources each feed a FIFO_DEPTH-word elastic buffer. Whole packets
// (header + LEN payload words, LEN = header[63:48]) are forwarded onto Q, one
// packet at a time, with the grant rotating round-robin between sources at
// packet boundaries.
//
// Handshake (VALID/BP): a word moves on every clock edge where its VALID is
// high; there is no ready qualifier on the transfer itself. BP is advisory
// backpressure: the receiver raises it early enough that the sender, reacting
// within its allowed slack, never overruns the receiver's buffer.
//
// Ports:
//   CLK, SYS_RST          clock; synchronous active-high reset
//   S0_D/S0_VALID/S0_BP   source 0 data, word valid, backpressure out
//   S1_D/S1_VALID/S1_BP   source 1, same as source 0
//   Q/Q_VALID             merged registered output towards the PE
//   Q_BP                  backpressure from the PE (registered once inside)
//   PKT_CNT0/PKT_CNT1     completed-packet counters (only with PE_ARB_STATS_EN)
//   dbg_state             current arbiter FSM state (IDLE=0, XFER0=1, XFER1=2)
//
// Optional feature macro: PE_ARB_STATS_EN adds the per-source packet counters.

module pe_in_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int BP_THRESH  = 2
) (
  input  logic        CLK,
  input  logic        SYS_RST,
  input  logic [63:0] S0_D,
  input  logic        S0_VALID,
  output logic        S0_BP,
  input  logic [63:0] S1_D,
  input  logic        S1_VALID,
  output logic        S1_BP,
  output logic [63:0] Q,
  output logic        Q_VALID,
  input  logic        Q_BP,
`ifdef PE_ARB_STATS_EN
  output logic [31:0] PKT_CNT0,
  output logic [31:0] PKT_CNT1,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Source buffers
  // ---------------------------------------------------------------------------
  logic [63:0]   mem    [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] count  [2];
  logic [63:0]   din    [2];
  logic [63:0]   head   [2];
  logic [1:0]    vin;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    not_empty;

  assign din[0] = S0_D;
  assign din[1] = S1_D;
  assign vin    = {S1_VALID, S0_VALID};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      head[s]      = mem[s][rd_ptr[s]];
      not_empty[s] = (count[s] != '0);
      // A pop in the same cycle frees a slot, so a full buffer still accepts.
      push[s]      = vin[s] && ((count[s] != CW'(FIFO_DEPTH)) || pop[s]);
    end
  end

  assign S0_BP = (count[0] >= CW'(BP_THRESH));
  assign S1_BP = (count[1] >= CW'(BP_THRESH));

  // Storage needs no reset: pointers and counts decide what is valid.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= din[s];
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + AW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + AW'(1);
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: count[s] <= count[s];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic        last, last_nxt;
  logic [15:0] rem, rem_nxt;
  logic        bp_q;
  logic        sel;
  logic        pkt_end;
  logic [63:0] head_sel;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    rem_nxt   = rem;
    pop       = 2'b00;
    pkt_end   = 1'b0;
    sel       = (state == XFER1);
    head_sel  = sel ? head[1] : head[0];

    case (state)
      IDLE: begin
        if (not_empty[0] && not_empty[1]) state_nxt = last ? XFER0 : XFER1;
        else if (not_empty[0])            state_nxt = XFER0;
        else if (not_empty[1])            state_nxt = XFER1;
      end
      XFER0, XFER1: begin
        if (not_empty[sel] && !bp_q) begin
          pop[sel] = 1'b1;
          // rem is zero exactly when the next word of the packet is its header:
          // it is cleared by reset and left at zero by every packet end.
          if (rem == 16'd0) begin
            rem_nxt = head_sel[63:48];
            pkt_end = (head_sel[63:48] == 16'd0);
          end else begin
            rem_nxt = rem - 16'd1;
            pkt_end = (rem == 16'd1);
          end
          if (pkt_end) begin
            state_nxt = IDLE;
            last_nxt  = sel;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      state   <= IDLE;
      last    <= 1'b1;
      rem     <= 16'd0;
      bp_q    <= 1'b0;
      Q       <= 64'd0;
      Q_VALID <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      rem     <= rem_nxt;
      bp_q    <= Q_BP;
      Q_VALID <= (pop != 2'b00);
      if (pop != 2'b00) Q <= head_sel;
    end
  end

`ifdef PE_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      PKT_CNT0 <= 32'd0;
      PKT_CNT1 <= 32'd0;
    end else begin
      PKT_CNT0 <= PKT_CNT0 + {31'd0, pkt_end & ~sel};
      PKT_CNT1 <= PKT_CNT1 + {31'd0, pkt_end & sel};
    end
  end
`endif

endmodule

// File: tb/tb_pe_in_arb.sv
// tb_pe_in_arb -- self-checking bench for pe_in_arb.
// Expected Q words are queued when a packet is scheduled and compared by a
// monitor on the falling edge; cycle stamps of observed words drive the timing
// checks. A table of single-packet vectors is followed by hand-written
// contention, backpressure, header-only, reset and starvation sequences.

module tb_pe_in_arb;

  logic        CLK = 1'b0;
  logic        SYS_RST;
  logic [63:0] S0_D, S1_D;
  logic        S0_VALID, S1_VALID;
  logic        S0_BP, S1_BP;
  logic [63:0] Q;
  logic        Q_VALID;
  logic        Q_BP;
  logic [1:0]  dbg_state;
`ifdef PE_ARB_STATS_EN
  logic [31:0] PKT_CNT0, PKT_CNT1;
`endif

  pe_in_arb #(.FIFO_DEPTH(4), .BP_THRESH(2)) dut (
    .CLK(CLK), .SYS_RST(SYS_RST),
    .S0_D(S0_D), .S0_VALID(S0_VALID), .S0_BP(S0_BP),
    .S1_D(S1_D), .S1_VALID(S1_VALID), .S1_BP(S1_BP),
    .Q(Q), .Q_VALID(Q_VALID), .Q_BP(Q_BP),
`ifdef PE_ARB_STATS_EN
    .PKT_CNT0(PKT_CNT0), .PKT_CNT1(PKT_CNT1),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];
  int          obs_cyc[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(negedge CLK) begin
    if (!SYS_RST && Q_VALID) begin
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL q_unexpected: got %h expected no word", Q);
      end else begin
        check("q_data", Q, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] pkt_word(input int src, input int len, input int tag, input int i);
    if (i == 0) return {16'(len), 8'(src), 8'(tag), 32'hC0DE0000 | 32'(tag)};
    else        return {16'(i), 8'(src), 8'(tag), 32'(tag * 1000 + i) ^ 32'h5A5A5A5A};
  endfunction

  task automatic set_src(input int src, input logic v, input logic [63:0] d);
    if (src == 0) begin S0_VALID = v; S0_D = d; end
    else          begin S1_VALID = v; S1_D = d; end
  endtask

  function automatic logic src_bp(input int src);
    return (src == 0) ? S0_BP : S1_BP;
  endfunction

  task automatic expect_pkt(input int src, input int len, input int tag);
    for (int i = 0; i <= len; i++) exp_q.push_back(pkt_word(src, len, tag, i));
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic drive_pkt(input int src, input int len, input int tag, input bit honour);
    int i = 0;
    int guard = 0;
    while (i <= len) begin
      if (honour && src_bp(src)) begin
        set_src(src, 1'b0, 64'd0);
        guard++;
        if (guard > 200) begin
          n_total++;
          $display("FAIL drive_timeout: src %0d stuck on BP, got %0d words sent expected %0d", src, i, len + 1);
          break;
        end
      end else begin
        set_src(src, 1'b1, pkt_word(src, len, tag, i));
        i++;
      end
      @(posedge CLK); #1;
    end
    set_src(src, 1'b0, 64'd0);
  endtask

  task automatic do_reset();
    SYS_RST = 1'b1;
    set_src(0, 1'b0, 64'd0);
    set_src(1, 1'b0, 64'd0);
    Q_BP = 1'b0;
    @(posedge CLK); #1;
    SYS_RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge CLK); #1;
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int src;
    int len;
    int exp_words;
    int exp_lat;   // header capture edge to first Q_VALID edge
    int exp_span;  // first to last Q word, in cycles (contiguous stream)
  } vec_t;

  vec_t tbl[5];

  int base, hdr_cyc, c0, win_cnt, tail_cnt;
  bit bp_seen;

  initial begin
    tbl[0] = '{0, 3, 4, 2, 3};
    tbl[1] = '{1, 0, 1, 2, 0};
    tbl[2] = '{1, 5, 6, 2, 5};
    tbl[3] = '{0, 1, 2, 2, 1};
    tbl[4] = '{1, 2, 3, 2, 2};

    SYS_RST = 1'b1;
    S0_D = '0; S1_D = '0; S0_VALID = 1'b0; S1_VALID = 1'b0; Q_BP = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    SYS_RST = 1'b0;
    @(negedge CLK);
    check("rst_q_valid", Q_VALID, 0);
    check("rst_q", Q, 0);
    check("rst_s0_bp", S0_BP, 0);
    check("rst_s1_bp", S1_BP, 0);
    check("rst_state", dbg_state, 0);
`ifdef PE_ARB_STATS_EN
    check("rst_cnt0", PKT_CNT0, 0);
    check("rst_cnt1", PKT_CNT1, 0);
`endif
    @(posedge CLK); #1;

    // ---- single packets from the table ----
    for (int t = 0; t < 5; t++) begin
      base    = obs_cyc.size();
      hdr_cyc = cyc + 1;
      expect_pkt(tbl[t].src, tbl[t].len, t + 1);
      drive_pkt(tbl[t].src, tbl[t].len, t + 1, 1'b0);
      wait_drain("tbl_drain", 50);
      check("tbl_words", obs_cyc.size() - base, tbl[t].exp_words);
      if (obs_cyc.size() > base) begin
        check("tbl_latency", obs_cyc[base] - hdr_cyc, tbl[t].exp_lat);
        check("tbl_span", obs_cyc[obs_cyc.size() - 1] - obs_cyc[base], tbl[t].exp_span);
      end
    end
    @(negedge CLK);
    check("hold_q_valid", Q_VALID, 0);
    check("hold_q", Q, pkt_word(1, 2, 5, 2));
    @(posedge CLK); #1;

    // ---- contention: S0 preferred after reset, then rotation ----
    do_reset();
    base = obs_cyc.size();
    expect_pkt(0, 1, 10);
    expect_pkt(1, 1, 11);
    fork
      drive_pkt(0, 1, 10, 1'b0);
      drive_pkt(1, 1, 11, 1'b0);
    join
    wait_drain("cont1_drain", 50);
    check("cont1_words", obs_cyc.size() - base, 4);
    if (obs_cyc.size() >= base + 4) begin
      check("cont1_pkt0_contig", obs_cyc[base + 1] - obs_cyc[base], 1);
      check("cont1_idle_gap", obs_cyc[base + 2] - obs_cyc[base + 1], 2);
    end
    expect_pkt(0, 1, 12);
    expect_pkt(1, 1, 13);
    fork
      drive_pkt(0, 1, 12, 1'b0);
      drive_pkt(1, 1, 13, 1'b0);
    join
    wait_drain("cont2_drain", 50);
    // S0 served alone makes S0 last, so a tie must now go to S1.
    expect_pkt(0, 0, 14);
    drive_pkt(0, 0, 14, 1'b0);
    wait_drain("cont3a_drain", 50);
    expect_pkt(1, 1, 15);
    expect_pkt(0, 1, 16);
    fork
      drive_pkt(0, 1, 16, 1'b0);
      drive_pkt(1, 1, 15, 1'b0);
    join
    wait_drain("cont3b_drain", 50);

    // ---- backpressure mid-packet ----
    do_reset();
    base    = obs_cyc.size();
    bp_seen = 1'b0;
    c0      = 0;
    expect_pkt(0, 10, 20);
    fork
      drive_pkt(0, 10, 20, 1'b1);
      begin
        int k = 0;
        while (obs_cyc.size() < base + 2 && k < 100) begin
          @(negedge CLK); #1;
          k++;
        end
        @(posedge CLK); #1;
        c0   = cyc;
        Q_BP = 1'b1;
        repeat (5) begin
          @(posedge CLK); #1;
          if (S0_BP) bp_seen = 1'b1;
        end
        Q_BP = 1'b0;
      end
    join
    wait_drain("bp_drain", 100);
    win_cnt  = 0;
    tail_cnt = 0;
    foreach (obs_cyc[i]) begin
      if (i >= base && obs_cyc[i] >= c0 + 1 && obs_cyc[i] <= c0 + 6) win_cnt++;
      if (i >= base && obs_cyc[i] >= c0 + 2 && obs_cyc[i] <= c0 + 6) tail_cnt++;
    end
    check("bp_words_after_rise_le1", (win_cnt <= 1), 1);
    check("bp_words_while_stalled", tail_cnt, 0);
    check("bp_s0_bp_seen", bp_seen, 1);
    check("bp_words", obs_cyc.size() - base, 11);

    // ---- header-only packets back-to-back ----
    do_reset();
    base = obs_cyc.size();
    for (int t = 0; t < 3; t++) expect_pkt(1, 0, 30 + t);
    for (int t = 0; t < 3; t++) drive_pkt(1, 0, 30 + t, 1'b0);
    wait_drain("hdr_drain", 50);
    check("hdr_words", obs_cyc.size() - base, 3);
    if (obs_cyc.size() >= base + 3) begin
      check("hdr_gap1", obs_cyc[base + 1] - obs_cyc[base], 2);
      check("hdr_gap2", obs_cyc[base + 2] - obs_cyc[base + 1], 2);
    end
`ifdef PE_ARB_STATS_EN
    check("hdr_cnt1", PKT_CNT1, 3);
    check("hdr_cnt0", PKT_CNT0, 0);
`endif

    // ---- reset in the middle of a packet ----
    do_reset();
    base = obs_cyc.size();
    expect_pkt(0, 5, 40);
    fork
      drive_pkt(0, 5, 40, 1'b0);
      begin
        int k = 0;
        while (obs_cyc.size() < base + 3 && k < 100) begin
          @(negedge CLK); #1;
          k++;
        end
        SYS_RST = 1'b1;
        @(posedge CLK); #1;
        SYS_RST = 1'b0;
      end
    join
    exp_q.delete();
    @(negedge CLK);
    check("mrst_q_valid", Q_VALID, 0);
    check("mrst_s0_bp", S0_BP, 0);
    check("mrst_s1_bp", S1_BP, 0);
    check("mrst_state", dbg_state, 0);
`ifdef PE_ARB_STATS_EN
    check("mrst_cnt0", PKT_CNT0, 0);
    check("mrst_cnt1", PKT_CNT1, 0);
`endif
    check("mrst_words_before", obs_cyc.size() - base, 3);
    @(posedge CLK); #1;
    base    = obs_cyc.size();
    hdr_cyc = cyc + 1;
    expect_pkt(1, 0, 41);
    drive_pkt(1, 0, 41, 1'b0);
    wait_drain("mrst_fresh_drain", 50);
    check("mrst_fresh_words", obs_cyc.size() - base, 1);
    if (obs_cyc.size() > base) check("mrst_fresh_latency", obs_cyc[base] - hdr_cyc, 2);
    check("mrst_fresh_state", dbg_state, 0);

    // ---- starvation hold: S0 stalls after its header ----
    do_reset();
    base = obs_cyc.size();
    expect_pkt(0, 2, 50);
    expect_pkt(1, 1, 51);
    set_src(0, 1'b1, pkt_word(0, 2, 50, 0));
    @(posedge CLK); #1;
    set_src(0, 1'b0, 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    drive_pkt(1, 1, 51, 1'b1);
    repeat (6) @(posedge CLK);
    #1;
    check("starve_words_held", obs_cyc.size() - base, 1);
    check("starve_s1_bp", S1_BP, 1);
    for (int i = 1; i <= 2; i++) begin
      set_src(0, 1'b1, pkt_word(0, 2, 50, i));
      @(posedge CLK); #1;
    end
    set_src(0, 1'b0, 64'd0);
    wait_drain("starve_drain", 50);
    check("starve_words", obs_cyc.size() - base, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
